// File: rtl/counter_pkg.sv
// Shared constants and elaboration helpers for the cascadable up counter family.
package counter_pkg;

    // Common per-digit moduli.
    localparam int RADIX_BCD         = 10;
    localparam int RADIX_HEX         = 16;
    localparam int RADIX_SEXAGESIMAL = 60;   // needs DIGIT_W >= 6

    // Ceiling log2 usable in constant expressions.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >>> 1;
        end
        return result;
    endfunction

    // True when a digit of digit_w bits can hold every value 0..radix-1.
    function automatic bit radix_fits(input int radix, input int digit_w);
        return (radix >= 2) && (clog2(radix) <= digit_w);
    endfunction

endpackage : counter_pkg

// File: rtl/up_counter_cascade_digit.sv
// One counter digit: holds 0..RADIX-1, increments on inc_in, passes carry on at max.
module up_counter_digit
    import counter_pkg::*;
#(
    parameter int RADIX   = RADIX_BCD,
    parameter int DIGIT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_val,
    input  logic               inc_in,
    output logic [DIGIT_W-1:0] q,
    output logic               at_max,
    output logic               inc_out,
    output logic               load_bad
);

    // One extra bit so RADIX == 2**DIGIT_W is representable in the compare.
    localparam logic [DIGIT_W:0]   RADIX_EXT = (DIGIT_W + 1)'(RADIX);
    localparam logic [DIGIT_W-1:0] MAX_VAL   = DIGIT_W'(RADIX - 1);
    localparam logic [DIGIT_W-1:0] ZERO_VAL  = DIGIT_W'(0);
    localparam logic [DIGIT_W-1:0] ONE_VAL   = DIGIT_W'(1);

    logic [DIGIT_W-1:0] count_r;
    logic [DIGIT_W-1:0] load_clean_s;

    // Range check of the incoming load digit, max detect and carry propagation.
    always_comb begin
        load_bad = ({1'b0, load_val} >= RADIX_EXT);
        if (load_bad) begin
            load_clean_s = ZERO_VAL;
        end else begin
            load_clean_s = load_val;
        end
        at_max  = (count_r == MAX_VAL);
        inc_out = inc_in & at_max;
    end

    // Digit register with priority rst > clr > load > increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= ZERO_VAL;
        end else if (clr) begin
            count_r <= ZERO_VAL;
        end else if (load) begin
            count_r <= load_clean_s;
        end else if (inc_in) begin
            count_r <= at_max ? ZERO_VAL : (count_r + ONE_VAL);
        end else begin
            count_r <= count_r;
        end
    end

    assign q = count_r;

endmodule : up_counter_digit

// File: rtl/up_counter_cascade.sv
// Synchronous multi-digit up counter with wrap/saturate, terminal count and carry-out.
module up_counter_cascade
    import counter_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int RADIX   = RADIX_BCD,
    parameter int DIGIT_W = 4,
    parameter int WRAP    = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        load,
    input  logic [DIGITS*DIGIT_W-1:0]   load_val,
    input  logic                        en,
    output logic [DIGITS*DIGIT_W-1:0]   q,
    output logic                        tc,
    output logic                        co,
    output logic                        sat,
    output logic                        ld_err
);

    if (!radix_fits(RADIX, DIGIT_W)) begin : g_bad_radix
        $error("up_counter_cascade: RADIX does not fit in DIGIT_W bits");
    end

    localparam logic WRAP_EN = (WRAP != 0);

    logic [DIGITS-1:0] at_max_s;
    logic [DIGITS-1:0] load_bad_s;
    logic [DIGITS-1:0] inc_chain_s;
    logic              all_max_s;
    logic              count_en_s;
    logic              co_r;
    logic              ld_err_r;

    // Max detect; in saturate mode the carry chain is starved once the count is full.
    always_comb begin
        all_max_s = &at_max_s;
        if (!WRAP_EN && all_max_s) begin
            count_en_s = 1'b0;
        end else begin
            count_en_s = en;
        end
        tc  = en & all_max_s;
        sat = ~WRAP_EN & all_max_s;
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic inc_in_s;
        if (i == 0) begin : g_first
            assign inc_in_s = count_en_s;
        end else begin : g_next
            assign inc_in_s = inc_chain_s[i-1];
        end

        up_counter_digit #(
            .RADIX   (RADIX),
            .DIGIT_W (DIGIT_W)
        ) u_digit (
            .clk      (clk),
            .rst      (rst),
            .clr      (clr),
            .load     (load),
            .load_val (load_val[i*DIGIT_W +: DIGIT_W]),
            .inc_in   (inc_in_s),
            .q        (q[i*DIGIT_W +: DIGIT_W]),
            .at_max   (at_max_s[i]),
            .inc_out  (inc_chain_s[i]),
            .load_bad (load_bad_s[i])
        );
    end

    // Registered carry-out on wrap and one-cycle flag for a sanitized load.
    always_ff @(posedge clk) begin
        if (rst) begin
            co_r     <= 1'b0;
            ld_err_r <= 1'b0;
        end else if (clr) begin
            co_r     <= 1'b0;
            ld_err_r <= 1'b0;
        end else if (load) begin
            co_r     <= 1'b0;
            ld_err_r <= |load_bad_s;
        end else begin
            co_r     <= WRAP_EN & inc_chain_s[DIGITS-1];
            ld_err_r <= 1'b0;
        end
    end

    assign co     = co_r;
    assign ld_err = ld_err_r;

endmodule : up_counter_cascade

// File: doc/up_counter_cascade.md
Name: up_counter_cascade

Overview:
- Synchronous, cascadable multi-digit up counter: DIGITS digits, each counting 0..RADIX-1. Default is a 4-digit BCD counter.
- Counterpart to the team's down counters: counts upward on a single clock, with no ripple clocking.
- Provides synchronous clear, parallel load, count enable, a terminal-count output and a carry-out pulse for chaining into a further counter.
- Used for event/timing counters and for human-readable (BCD) counts.

Parameters:
- DIGITS, 4, number of digits.
- RADIX, 10, modulus of each digit; 2 ≤ RADIX ≤ 2^DIGIT_W.
- DIGIT_W, 4, bits per digit.
- WRAP, 1: 1 = wrap to zero after max; 0 = saturate at max.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- clr  in  1  synchronous clear to zero.
- load  in  1  synchronous parallel load.
- load_val  in  DIGITS*DIGIT_W  load value; digit i is bits [i*DIGIT_W +: DIGIT_W].
- en  in  1  count enable; +1 per enabled cycle.
- q  out  DIGITS*DIGIT_W  count value, same digit packing as load_val.
- tc  out  1  terminal count (combinational): en & (every digit == RADIX-1).
- co  out  1  registered carry-out pulse, one cycle, on wrap.
- sat  out  1  (combinational) WRAP=0 and q at max.
- ld_err  out  1  registered pulse: the last load contained a digit ≥ RADIX.

Behaviour:
- Priority per edge: rst > clr > load > en. Lower-priority inputs are ignored that cycle.
- rst: q=0, co=0, ld_err=0. Since q=0, sat=0 and tc=0. Takes effect on the edge where rst is sampled high, including mid-count with en=1.
- clr: q=0, co=0, ld_err=0.
- load: each digit takes its load_val digit.
  - Any digit ≥ RADIX is stored as 0 instead.
  - ld_err=1 for exactly the cycle after such a load, else 0.
  - co=0 on a load edge.
- en (no rst/clr/load):
  - Digit i increments when en=1 and all digits below i equal RADIX-1.
  - A digit at RADIX-1 that increments goes to 0.
  - All digits update on the same edge (synchronous carry chain, combinational enable ripple). Latency: q reflects the increment one clock after en is sampled.
- Max state (all digits RADIX-1) with en=1:
  - WRAP=1: q→0 and co=1 for the following cycle only.
  - WRAP=0: q holds at max, co stays 0, sat stays 1 for as long as q is at max.
- en=0: q holds; co=0 next cycle.
- tc is combinational and may be used as the en of a downstream stage in the same cycle. co is the registered form of the same event.
- No X propagation: all outputs are defined from the first edge with rst=1.
- Out-of-range digits can only arise from load, and load sanitizes them; the counter never leaves 0..RADIX-1 per digit.

Decomposition:
- counter_pkg holds:
  - default RADIX constants: BCD=10, HEX=16, SEXAGESIMAL=60 (the last needs DIGIT_W ≥ 6);
  - a clog2 function;
  - an elaboration check that 2^DIGIT_W ≥ RADIX.
- Sub-module up_counter_digit: one digit, instantiated DIGITS times in a generate loop.
  - Ports: clk, rst, clr, load, load_val[DIGIT_W], inc_in, q[DIGIT_W], at_max, inc_out.
  - inc_out = inc_in & at_max.
  - It also reports load invalidity to the top level.
- The top level handles WRAP/saturate gating, tc, co, sat and ld_err.

Test Plan:
- rst=1 with en=1 and load=1 for one edge → q=0x0000, co=0, ld_err=0, sat=0. Repeat mid-count at q=0x0347 → q=0x0000 on that edge.
- From 0, en=1 for 12 cycles → q=0x0012. On the 10th edge, digit0 goes 9→0 and digit1 goes 0→1 together. At 99 → 100, q=0x0100 in a single edge.
- WRAP=1, load 0x9998, then en=1:
  - after edge 1: q=0x9999, tc=1;
  - after edge 2: q=0x0000, co=1 for exactly one cycle, tc=0;
  - after edge 3: q=0x0001, co=0.
- WRAP=0, load 0x9998, en=1 for 5 cycles → q=0x9999 from edge 1 onward, sat=1, co never asserted. Then clr=1 → q=0x0000, sat=0.
- Load 0x12A4 → q=0x1204, ld_err=1 for one cycle. Load 0x5678 → ld_err=0.
- Simultaneous inputs:
  - load 0x0500 with en=1 → q=0x0500 (not 0x0501);
  - clr with load 0x4321 → q=0x0000;
  - en toggling 1,0,1 from 0x0009 → 0x0010, 0x0010, 0x0011.
